inlet_dose_sequencer: RTL and testbench

//  Upstream controller for the smart_toilet mixing chip. Drives the soln1/soln2/soln3

---
 rtl/inlet_dose_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_inlet_dose_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inlet_dose_sequencer.sv
// rtl/inlet_dose_sequencer.sv - timed inlet/flush/pump sequencer for the mixing chip
//
// Purpose: opens soln3, then soln2, then soln1 in a staggered lead-in so all three
// streams reach their mixers together. It then doses with all three open, flushes,
// and pulses done. The host starts a run with start and can cut it short with abort.
//
// Ports:
//   clk          in   rising-edge system clock
//   rst_n        in   synchronous active-low reset
//   start        in   run request, only honoured in IDLE
//   abort        in   early termination, honoured in LEAD3/LEAD2/LEAD1/DOSE
//   busy         out  run in progress (LEAD3..FLUSH)
//   done         out  one-cycle pulse in DONE
//   aborted      out  last run was cut short; cleared when the next run starts
//   valve_soln1  out  soln1 inlet open
//   valve_soln2  out  soln2 inlet open
//   valve_soln3  out  soln3 inlet open
//   valve_flush  out  flush inlet open
//   pump_en      out  pressure pump on
//   phase        out  current state code
module inlet_dose_sequencer #(
  parameter int CNT_W   = 16,
  parameter int T_LEAD3 = 300,
  parameter int T_LEAD2 = 150,
  parameter int T_LEAD1 = 25,
  parameter int T_DOSE  = 1000,
  parameter int T_FLUSH = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       valve_soln1,
  output logic       valve_soln2,
  output logic       valve_soln3,
  output logic       valve_flush,
  output logic       pump_en,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD3 = 3'd1,
    S_LEAD2 = 3'd2,
    S_LEAD1 = 3'd3,
    S_DOSE  = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Refuse to build with a duration the counter cannot hold.
  if (T_LEAD3 > CNT_MAX || T_LEAD2 > CNT_MAX || T_LEAD1 > CNT_MAX ||
      T_DOSE > CNT_MAX || T_FLUSH > CNT_MAX) begin : g_bad_duration
    $error("inlet_dose_sequencer: a T_* duration exceeds the CNT_W counter range");
  end

  // Counter preload: a state lasts max(T,1) cycles, so it loads max(T,1)-1 and
  // advances on the edge where the counter reads zero.
  function automatic logic [CNT_W-1:0] load_val(input int t);
    int v;
    v = (t <= 1) ? 0 : t - 1;
    return v[CNT_W-1:0];
  endfunction

  localparam logic [CNT_W-1:0] LD_LEAD3 = load_val(T_LEAD3);
  localparam logic [CNT_W-1:0] LD_LEAD2 = load_val(T_LEAD2);
  localparam logic [CNT_W-1:0] LD_LEAD1 = load_val(T_LEAD1);
  localparam logic [CNT_W-1:0] LD_DOSE  = load_val(T_DOSE);
  localparam logic [CNT_W-1:0] LD_FLUSH = load_val(T_FLUSH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aborted_q, aborted_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             soln1_q, soln1_d;
  logic             soln2_q, soln2_d;
  logic             soln3_q, soln3_d;
  logic             flush_q, flush_d;
  logic             pump_q, pump_d;

  // Next state, counter and sticky aborted flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        // start beats a simultaneous abort: abort means nothing in IDLE.
        if (start) begin
          state_d   = S_LEAD3;
          cnt_d     = LD_LEAD3;
          aborted_d = 1'b0;
        end
      end
      S_LEAD3, S_LEAD2, S_LEAD1, S_DOSE: begin
        // Abort is checked before expiry so it wins when both land together.
        if (abort) begin
          state_d   = S_FLUSH;
          cnt_d     = LD_FLUSH;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          case (state_q)
            S_LEAD3: begin state_d = S_LEAD2; cnt_d = LD_LEAD2; end
            S_LEAD2: begin state_d = S_LEAD1; cnt_d = LD_LEAD1; end
            S_LEAD1: begin state_d = S_DOSE;  cnt_d = LD_DOSE;  end
            default: begin state_d = S_FLUSH; cnt_d = LD_FLUSH; end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        // Code 7 cannot be reached in normal operation; fall back to IDLE.
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with phase.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    soln1_d = 1'b0;
    soln2_d = 1'b0;
    soln3_d = 1'b0;
    flush_d = 1'b0;
    case (state_d)
      S_LEAD3: begin busy_d = 1'b1; soln3_d = 1'b1; end
      S_LEAD2: begin busy_d = 1'b1; soln3_d = 1'b1; soln2_d = 1'b1; end
      S_LEAD1, S_DOSE: begin
        busy_d  = 1'b1;
        soln3_d = 1'b1;
        soln2_d = 1'b1;
        soln1_d = 1'b1;
      end
      S_FLUSH: begin busy_d = 1'b1; flush_d = 1'b1; end
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
    pump_d = busy_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      soln1_q   <= 1'b0;
      soln2_q   <= 1'b0;
      soln3_q   <= 1'b0;
      flush_q   <= 1'b0;
      pump_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      soln1_q   <= soln1_d;
      soln2_q   <= soln2_d;
      soln3_q   <= soln3_d;
      flush_q   <= flush_d;
      pump_q    <= pump_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign valve_soln1 = soln1_q;
  assign valve_soln2 = soln2_q;
  assign valve_soln3 = soln3_q;
  assign valve_flush = flush_q;
  assign pump_en     = pump_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// tb/tb_inlet_dose_sequencer.sv - self-checking bench for inlet_dose_sequencer
module tb_inlet_dose_sequencer;

  localparam int D3 = 4, D2 = 3, D1 = 2, DD = 5, DF = 3;
  localparam int Z2 = 0, Z1 = 0;

  logic clk, rst_n, start, abort;
  logic busy, done, aborted, v1, v2, v3, vf, pump;
  logic [2:0] phase;
  logic busy_z, done_z, aborted_z, v1_z, v2_z, v3_z, vf_z, pump_z;
  logic [2:0] phase_z;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  inlet_dose_sequencer #(.CNT_W(16), .T_LEAD3(D3), .T_LEAD2(D2), .T_LEAD1(D1),
                         .T_DOSE(DD), .T_FLUSH(DF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .valve_soln1(v1), .valve_soln2(v2), .valve_soln3(v3), .valve_flush(vf),
    .pump_en(pump), .phase(phase));

  inlet_dose_sequencer #(.CNT_W(16), .T_LEAD3(D3), .T_LEAD2(Z2), .T_LEAD1(Z1),
                         .T_DOSE(DD), .T_FLUSH(DF)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy_z), .done(done_z), .aborted(aborted_z),
    .valve_soln1(v1_z), .valve_soln2(v2_z), .valve_soln3(v3_z), .valve_flush(vf_z),
    .pump_en(pump_z), .phase(phase_z));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on an accepted start the whole run is written out as a list of
  // per-cycle phases; an abort rewrites the remaining list as flush + done.
  int plan [2][0:63];
  int head [2];
  int tail [2];
  int cur  [2];
  bit mab  [2];

  function automatic int eff(input int t);
    return (t < 1) ? 1 : t;
  endfunction

  function automatic int dur(input int k, input int ph);
    case (ph)
      1: return eff(D3);
      2: return eff(k == 0 ? D2 : Z2);
      3: return eff(k == 0 ? D1 : Z1);
      4: return eff(DD);
      default: return eff(DF);
    endcase
  endfunction

  task automatic push(input int k, input int ph, input int n);
    for (int j = 0; j < n; j++) begin
      plan[k][tail[k]] = ph;
      tail[k]++;
    end
  endtask

  task automatic mstep(input int k);
    if (!rst_n) begin
      head[k] = 0; tail[k] = 0; cur[k] = 0; mab[k] = 0;
    end else begin
      if (cur[k] == 0 && start) begin
        head[k] = 0; tail[k] = 0;
        for (int p = 1; p <= 5; p++) push(k, p, dur(k, p));
        push(k, 6, 1);
        mab[k] = 0;
      end else if (cur[k] >= 1 && cur[k] <= 4 && abort) begin
        head[k] = 0; tail[k] = 0;
        push(k, 5, dur(k, 5));
        push(k, 6, 1);
        mab[k] = 1;
      end
      if (head[k] < tail[k]) begin
        cur[k] = plan[k][head[k]];
        head[k]++;
      end else begin
        cur[k] = 0;
      end
    end
  endtask

  // {phase, busy, done, aborted, soln1, soln2, soln3, flush, pump}
  function automatic logic [10:0] exp_vec(input int p, input bit ab);
    logic bz;
    bz = (p >= 1 && p <= 5);
    return {p[2:0], bz, p == 6, ab, p == 3 || p == 4, p >= 2 && p <= 4,
            p >= 1 && p <= 4, p == 5, bz};
  endfunction

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_main", {phase, busy, done, aborted, v1, v2, v3, vf, pump},
          exp_vec(cur[0], mab[0]));
      chk("model_zero", {phase_z, busy_z, done_z, aborted_z, v1_z, v2_z, v3_z, vf_z, pump_z},
          exp_vec(cur[1], mab[1]));
    end
  end

  typedef struct {
    logic       st, ab, rn;
    logic [2:0] ph;
    logic [3:0] v;     // {flush, soln3, soln2, soln1}
    logic       bz, dn, abd;
  } vec_t;

  vec_t tv [20];

  function automatic vec_t mk(input logic st, ab, rn, input logic [2:0] ph,
                              input logic [3:0] v, input logic bz, dn, abd);
    vec_t r;
    r.st = st; r.ab = ab; r.rn = rn; r.ph = ph; r.v = v; r.bz = bz; r.dn = dn; r.abd = abd;
    return r;
  endfunction

  task automatic step(input logic s, input logic a, input logic r);
    start = s; abort = a; rst_n = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_both();
    step(0, 0, 0);
    rst_n = 1;
  endtask

  initial begin
    clk = 0; rst_n = 0; start = 0; abort = 0;

    // Abort in LEAD2, restart clears aborted, abort in LEAD3, start ignored in FLUSH.
    tv[0]  = mk(1, 0, 1, 3'd0, 4'b0000, 0, 0, 0);
    tv[1]  = mk(0, 0, 1, 3'd1, 4'b0100, 1, 0, 0);
    tv[2]  = mk(0, 0, 1, 3'd1, 4'b0100, 1, 0, 0);
    tv[3]  = mk(0, 0, 1, 3'd1, 4'b0100, 1, 0, 0);
    tv[4]  = mk(0, 0, 1, 3'd1, 4'b0100, 1, 0, 0);
    tv[5]  = mk(0, 0, 1, 3'd2, 4'b0110, 1, 0, 0);
    tv[6]  = mk(0, 1, 1, 3'd2, 4'b0110, 1, 0, 0);
    tv[7]  = mk(0, 0, 1, 3'd5, 4'b1000, 1, 0, 1);
    tv[8]  = mk(0, 0, 1, 3'd5, 4'b1000, 1, 0, 1);
    tv[9]  = mk(0, 0, 1, 3'd5, 4'b1000, 1, 0, 1);
    tv[10] = mk(0, 0, 1, 3'd6, 4'b0000, 0, 1, 1);
    tv[11] = mk(0, 0, 1, 3'd0, 4'b0000, 0, 0, 1);
    tv[12] = mk(1, 0, 1, 3'd0, 4'b0000, 0, 0, 1);
    tv[13] = mk(0, 0, 1, 3'd1, 4'b0100, 1, 0, 0);
    tv[14] = mk(0, 1, 1, 3'd1, 4'b0100, 1, 0, 0);
    tv[15] = mk(0, 0, 1, 3'd5, 4'b1000, 1, 0, 1);
    tv[16] = mk(1, 0, 1, 3'd5, 4'b1000, 1, 0, 1);
    tv[17] = mk(0, 0, 1, 3'd5, 4'b1000, 1, 0, 1);
    tv[18] = mk(0, 0, 1, 3'd6, 4'b0000, 0, 1, 1);
    tv[19] = mk(0, 0, 1, 3'd0, 4'b0000, 0, 0, 1);

    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("reset_outputs", {phase, busy, done, aborted, v1, v2, v3, vf, pump}, 11'd0);
    chk("reset_outputs_z", {phase_z, busy_z, done_z, aborted_z, v1_z, v2_z, v3_z, vf_z, pump_z}, 11'd0);
    rst_n = 1;

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("tbl%0d_phase", i), phase, tv[i].ph);
      chk($sformatf("tbl%0d_valves", i), {vf, v3, v2, v1}, tv[i].v);
      chk($sformatf("tbl%0d_busy", i), busy, tv[i].bz);
      chk($sformatf("tbl%0d_pump", i), pump, tv[i].bz);
      chk($sformatf("tbl%0d_done", i), done, tv[i].dn);
      chk($sformatf("tbl%0d_aborted", i), aborted, tv[i].abd);
      step(tv[i].st, tv[i].ab, tv[i].rn);
    end

    // Nominal run with ignored starts at 3 and 18 and an ignored abort in FLUSH.
    reset_both();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("nom%0d_s3", c), v3, c >= 1 && c <= 14);
      chk($sformatf("nom%0d_s2", c), v2, c >= 5 && c <= 14);
      chk($sformatf("nom%0d_s1", c), v1, c >= 8 && c <= 14);
      chk($sformatf("nom%0d_flush", c), vf, c >= 15 && c <= 17);
      chk($sformatf("nom%0d_busy", c), busy, c >= 1 && c <= 17);
      chk($sformatf("nom%0d_done", c), done, c == 18);
      chk($sformatf("nom%0d_aborted", c), aborted, 1'b0);
      chk($sformatf("zero%0d_done", c), done_z, c == 15);
      if (c >= 5 && c <= 14)
        chk($sformatf("zero%0d_s1", c), v1_z, c >= 6 && c <= 11);
      step(c == 0 || c == 3 || c == 18, c == 16, 1);
    end

    // start+abort together in IDLE, then abort on the last DOSE cycle.
    reset_both();
    for (int c = 0; c < 20; c++) begin
      if (c == 14) chk("sim_phase14", phase, 3'd4);
      if (c >= 15 && c <= 17) chk($sformatf("sim%0d_phase", c), phase, 3'd5);
      chk($sformatf("sim%0d_aborted", c), aborted, c >= 15);
      chk($sformatf("sim%0d_done", c), done, c == 18);
      chk($sformatf("sim%0d_s3", c), v3, c >= 1 && c <= 14);
      step(c == 0, c == 0 || c == 14, 1);
    end

    // Reset in the middle of a run, then a fresh start.
    reset_both();
    for (int c = 0; c < 16; c++) begin
      if (c == 10 || c == 11)
        chk($sformatf("rst%0d_all", c), {phase, busy, done, aborted, v1, v2, v3, vf, pump}, 11'd0);
      if (c == 13) chk("rst13_s3", v3, 1'b1);
      if (c == 12) chk("rst12_s3", v3, 1'b0);
      step(c == 0 || c == 12, 1'b0, c != 9);
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
